// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the 101101 sequence-detector front end.
//   state_t        : serializer FSM states (IDLE, SHIFT)
//   MODE_MEALY/MOORE: encodings of the detector mode bit M
//   DEFAULT_WIDTH  : default serialized word width
// -----------------------------------------------------------------------------
package seq_det_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic MODE_MEALY    = 1'b0;
    localparam logic MODE_MOORE    = 1'b1;
    localparam int   DEFAULT_WIDTH = 16;

endpackage

// File: rtl/sequence_bit_serializer_if.sv
// -----------------------------------------------------------------------------
// seq_in_if
// Word input channel of the serializer.
//   in_data  : word to serialize (WIDTH bits)
//   in_mode  : detector mode travelling with the word (0 Mealy, 1 Moore)
//   in_valid : producer has a word
//   in_ready : consumer can take a word
// Handshake: a word transfers on a rising clk edge where in_valid && in_ready.
// in_ready is registered and never depends on in_valid in the same cycle; the
// producer keeps in_data/in_mode stable while in_valid is high and not yet
// accepted.
// Modports: master = word producer, slave = serializer.
// -----------------------------------------------------------------------------
interface seq_in_if #(
    parameter int WIDTH = 16
) ();

    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic             in_valid;
    logic             in_ready;

    modport master (
        output in_data,
        output in_mode,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_mode,
        input  in_valid,
        output in_ready
    );

endinterface

// File: rtl/seq_hold_reg.sv
// -----------------------------------------------------------------------------
// seq_hold_reg
// Single-entry holding register (data + mode) with a registered ready.
//   clk, reset : clock, synchronous active-high reset
//   i_flush    : synchronous discard of the held word
//   i_pop      : consumer takes the held word this edge
//   in_if      : word input channel (slave side)
//   o_valid    : a word is held
//   o_data     : held word
//   o_mode     : held mode bit
// in_ready is the register complement of o_valid, so a word can only be
// accepted when the entry is already empty at the start of the cycle; an
// accept and a pop therefore never coincide.
// -----------------------------------------------------------------------------
module seq_hold_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_pop,
    seq_in_if.slave          in_if,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_mode
);

    logic             r_valid;
    logic             r_ready;
    logic [WIDTH-1:0] r_data;
    logic             r_mode;
    logic             w_accept;

    assign w_accept = in_if.in_valid && r_ready;

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
            r_data  <= '0;
            r_mode  <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_ready <= 1'b0;
            r_data  <= in_if.in_data;
            r_mode  <= in_if.in_mode;
        end else if (i_pop) begin
            r_valid <= 1'b0;
            r_ready <= 1'b1;
        end
    end

    assign in_if.in_ready = r_ready;
    assign o_valid        = r_valid;
    assign o_data         = r_data;
    assign o_mode         = r_mode;

endmodule

// File: rtl/sequence_bit_serializer.sv
// -----------------------------------------------------------------------------
// sequence_bit_serializer
// Streams WIDTH-bit words one bit per clock onto the detector input X, with a
// holding register in front of the shifter so consecutive words run gaplessly.
// The mode bit M is latched with each word when it enters the shifter.
//   clk, reset : clock, synchronous active-high reset
//   in_if      : word input channel (in_data, in_mode, in_valid, in_ready)
//   abort      : synchronous flush of holding register and shifter
//   X          : serial bit (0 whenever x_valid is low)
//   M          : detector mode for the word currently shifting
//   x_valid    : X carries a data bit
//   busy       : holding register or shifter occupied
//   words_done : count of fully shifted words (wraps)
//   state_dbg  : current FSM state
// Build option: define SERIALIZER_LSB_FIRST_EN to emit LSB first
// (default is MSB first).
// -----------------------------------------------------------------------------
module sequence_bit_serializer
    import seq_det_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    seq_in_if.slave          in_if,
    input  logic             abort,
    output logic             X,
    output logic             M,
    output logic             x_valid,
    output logic             busy,
    output logic [CNT_W-1:0] words_done,
    output state_t           state_dbg
);

    localparam int BC_W = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_shift;
    logic [BC_W-1:0]  r_bit_cnt;
    logic             r_mode;
    logic [CNT_W-1:0] r_words_done;

    logic             w_hold_valid;
    logic [WIDTH-1:0] w_hold_data;
    logic             w_hold_mode;
    logic             w_load;
    logic             w_last;
    logic             w_pop;
    logic [WIDTH-1:0] w_shifted;
    logic             w_out_bit;

    // An abort on the reload edge must not consume the held word: the flush
    // clears it anyway, and popping would be meaningless.
    assign w_pop = w_load && !abort;

    seq_hold_reg #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk     (clk),
        .reset   (reset),
        .i_flush (abort),
        .i_pop   (w_pop),
        .in_if   (in_if),
        .o_valid (w_hold_valid),
        .o_data  (w_hold_data),
        .o_mode  (w_hold_mode)
    );

`ifdef SERIALIZER_LSB_FIRST_EN
    assign w_shifted = {1'b0, r_shift[WIDTH-1:1]};
    assign w_out_bit = r_shift[0];
`else
    assign w_shifted = {r_shift[WIDTH-2:0], 1'b0};
    assign w_out_bit = r_shift[WIDTH-1];
`endif

    // Next-state / control
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_hold_valid) begin
                    w_load       = 1'b1;
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (r_bit_cnt == '0) begin
                    w_last = 1'b1;
                    // Reload straight from hold keeps the stream gapless.
                    if (w_hold_valid) begin
                        w_load       = 1'b1;
                        w_next_state = SHIFT;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register, shifter, mode latch and word counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_mode       <= MODE_MEALY;
            r_words_done <= '0;
        end else if (abort) begin
            // M and the word count survive an abort.
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_load) begin
                r_shift   <= w_hold_data;
                r_mode    <= w_hold_mode;
                r_bit_cnt <= BC_W'(WIDTH - 1);
            end else if (r_state == SHIFT) begin
                // After the last bit this leaves the shifter all zero.
                r_shift   <= w_shifted;
                r_bit_cnt <= r_bit_cnt - 1'b1;
            end
            if (w_last) begin
                r_words_done <= r_words_done + 1'b1;
            end
        end
    end

    assign x_valid    = (r_state == SHIFT);
    assign X          = x_valid && w_out_bit;
    assign M          = r_mode;
    assign busy       = w_hold_valid || (r_state == SHIFT);
    assign words_done = r_words_done;
    assign state_dbg  = r_state;

endmodule

// File: tb/tb_sequence_bit_serializer.sv
module tb_sequence_bit_serializer;
    import seq_det_pkg::*;

    localparam int W  = 16;
    localparam int CW = 2;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          reset;
    logic          abort;
    logic          X, M, x_valid, busy;
    logic [CW-1:0] words_done;
    state_t        state_dbg;

    always #5 clk = ~clk;

    seq_in_if #(.WIDTH(W)) bus ();

    sequence_bit_serializer #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_if      (bus),
        .abort      (abort),
        .X          (X),
        .M          (M),
        .x_valid    (x_valid),
        .busy       (busy),
        .words_done (words_done),
        .state_dbg  (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [1:0]    exp_q[$];      // {M, X} per emitted bit
    logic [CW-1:0] exp_wd_q[$];   // words_done after each completed word
    logic [CW-1:0] model_cnt;
    int            run_len;
    int            last_run;
    logic [CW-1:0] mon_prev_wd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout/empty expected event", name);
    endtask

    // ---------------- monitor ----------------
    initial begin
        logic [1:0] e;
        run_len     = 0;
        last_run    = 0;
        mon_prev_wd = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_prev_wd = words_done;
                run_len     = 0;
            end else begin
                if (x_valid) begin
                    run_len++;
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_bit");
                    end else begin
                        e = exp_q.pop_front();
                        check("bit_x", 32'(X), 32'(e[0]));
                        check("bit_m", 32'(M), 32'(e[1]));
                    end
                end else begin
                    if (run_len > 0) last_run = run_len;
                    run_len = 0;
                end
                if (words_done !== mon_prev_wd) begin
                    if (exp_wd_q.size() == 0) begin
                        fail_now("unexpected_words_done");
                    end else begin
                        check("words_done", 32'(words_done), 32'(exp_wd_q.pop_front()));
                    end
                    mon_prev_wd = words_done;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Offers one word; pushes the nbits that will be emitted and, if the word
    // runs to completion, the expected counter value.
    task automatic send(input logic [W-1:0] d, input logic md, input int nbits, input bit counted);
        int n;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_mode  = md;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) begin
            fail_now("accept_timeout");
            bus.in_valid = 1'b0;
            return;
        end
        for (int i = 0; i < nbits; i++) begin
`ifdef SERIALIZER_LSB_FIRST_EN
            exp_q.push_back({md, d[i]});
`else
            exp_q.push_back({md, d[W-1-i]});
`endif
        end
        if (counted) begin
            model_cnt = model_cnt + 1'b1;
            exp_wd_q.push_back(model_cnt);
        end
        @(posedge clk);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy !== 1'b0 || x_valid !== 1'b0) && n < 400) begin
            step();
            n++;
        end
        if (n >= 400) fail_now("idle_timeout");
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset     = 1'b0;
        model_cnt = '0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed tests ----------------
    initial begin
        logic first_bit;
        int   n;
        reset        = 1'b1;
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_mode  = 1'b0;
        model_cnt    = '0;
        step();
        do_reset();

        // Reset state
        check("rst_X",       32'(X),          32'd0);
        check("rst_M",       32'(M),          32'd0);
        check("rst_x_valid", 32'(x_valid),    32'd0);
        check("rst_busy",    32'(busy),       32'd0);
        check("rst_wd",      32'(words_done), 32'd0);
        check("rst_ready",   32'(bus.in_ready), 32'd1);
        check("rst_state",   32'(state_dbg),  32'(IDLE));

        // Single word B680, Moore
        send(16'hB680, 1'b1, 16, 1'b1);
        check("t1_not_yet_valid", 32'(x_valid), 32'd0);
        check("t1_busy_hold",     32'(busy),    32'd1);
        step();
`ifdef SERIALIZER_LSB_FIRST_EN
        first_bit = 1'b0;
`else
        first_bit = 1'b1;
`endif
        check("t1_latency_valid", 32'(x_valid), 32'd1);
        check("t1_latency_X",     32'(X),       32'(first_bit));
        wait_idle();
        check("t1_run_len",  32'(last_run),   32'd16);
        check("t1_idle_X",   32'(X),          32'd0);
        check("t1_idle_busy", 32'(busy),      32'd0);
        check("t1_M_held",   32'(M),          32'd1);
        check("t1_wd",       32'(words_done), 32'd1);

        // Back-to-back
        send(16'hB6B6, 1'b1, 16, 1'b1);
        send(16'h5B5B, 1'b1, 16, 1'b1);
        check("b2b_ready_low", 32'(bus.in_ready), 32'd0);
        wait_idle();
        check("b2b_run_len", 32'(last_run),   32'd32);
        check("b2b_wd",      32'(words_done), 32'd3);

        // Mode change between words (per-bit M checked by the monitor)
        send(16'hB6B6, 1'b0, 16, 1'b1);
        send(16'h5B5B, 1'b1, 16, 1'b1);
        wait_idle();
        check("mode_run_len", 32'(last_run), 32'd32);
        check("mode_M_final", 32'(M),        32'd1);

        // Abort on 5th bit of FFFF with 0001 pending
        send(16'hFFFF, 1'b0, 5, 1'b0);
        send(16'h0001, 1'b1, 0, 1'b0);
        check("abort_hold_full", 32'(bus.in_ready), 32'd0);
        n = 0;
        while (run_len != 5 && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) fail_now("abort_align_timeout");
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        step();
        check("abort_x_valid", 32'(x_valid),      32'd0);
        check("abort_X",       32'(X),            32'd0);
        check("abort_ready",   32'(bus.in_ready), 32'd1);
        check("abort_busy",    32'(busy),         32'd0);
        check("abort_wd",      32'(words_done),   32'(model_cnt));
        check("abort_M",       32'(M),            32'd0);
        check("abort_state",   32'(state_dbg),    32'(IDLE));
        for (int i = 0; i < 20; i++) step();
        check("abort_stays_idle", 32'(x_valid), 32'd0);

        // Counter wrap with CNT_W = 2: expect 1, 2, 3, 0, 1
        step();
        do_reset();
        check("wrap_rst_wd", 32'(words_done), 32'd0);
        send(16'h1234, 1'b0, 16, 1'b1);
        send(16'hA5A5, 1'b1, 16, 1'b1);
        send(16'h8001, 1'b0, 16, 1'b1);
        send(16'h7FFE, 1'b1, 16, 1'b1);
        send(16'h0F0F, 1'b0, 16, 1'b1);
        wait_idle();
        check("wrap_wd_final", 32'(words_done), 32'd1);

        step();
        check("sb_bits_drained",  32'(exp_q.size()),    32'd0);
        check("sb_words_drained", 32'(exp_wd_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
